// File: rtl/esticador_pulso.sv
// Pulse-to-level converter: a one-cycle strobe becomes a registered high level
// of len cycles, followed by GAP low guard cycles. Optional macro: RETRIGGER_EN.
module esticador_pulso #(
   parameter int unsigned W   = 8,
   parameter int unsigned GAP = 1
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         pulse_in,
   input  logic [W-1:0] len,
   input  logic         ovr_clr,
   output logic         out,
   output logic         busy,
   output logic         overrun
);

   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GW-1:0] GLOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

   typedef enum logic [1:0] {IDLE, ACTIVE, GUARD} state_t;

   state_t        state;
   logic [W-1:0]  cnt;
   logic [GW-1:0] gcnt;
   logic          trig;
   logic          drop;
   logic          reload;

   // len==0 never counts as a trigger, so it can neither start nor drop
   always_comb begin
      trig   = pulse_in && (len != '0);
      drop   = 1'b0;
      reload = 1'b0;
      case (state)
`ifdef RETRIGGER_EN
         ACTIVE:  reload = trig;
`else
         ACTIVE:  drop   = trig;
`endif
         GUARD:   drop   = trig;
         default: drop   = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state   <= IDLE;
         cnt     <= '0;
         gcnt    <= '0;
         out     <= 1'b0;
         busy    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         // a drop in the same cycle as ovr_clr keeps the flag set
         if (drop)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (trig) begin
                  state <= ACTIVE;
                  cnt   <= len - 1'b1;
                  out   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            ACTIVE: begin
               if (reload) begin
                  cnt <= len - 1'b1;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (GAP > 0) begin
                  state <= GUARD;
                  gcnt  <= GLOAD;
                  out   <= 1'b0;
               end else begin
                  state <= IDLE;
                  out   <= 1'b0;
                  busy  <= 1'b0;
               end
            end
            GUARD: begin
               if (gcnt != '0) begin
                  gcnt <= gcnt - 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               out   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_esticador_pulso.sv
// Scoreboard bench for esticador_pulso: three instances (GAP=0/W=4, GAP=1, GAP=2),
// expected {out,busy,overrun} queued per cycle and checked by a separate monitor.
module tb_esticador_pulso;

   logic       clk;
   logic       clr_n;
   logic       pulse;
   logic [7:0] len;
   logic       ovr_clr;
   int         sel;

   logic p0, p1, p2;
   logic o0, b0, v0, o1, b1, v1, o2, b2, v2;

   typedef struct {
      int         sel;
      logic [2:0] exp;
      string      name;
   } entry_t;

   entry_t q[$];
   int     total  = 0;
   int     passed = 0;

   assign p0 = (sel == 0) ? pulse : 1'b0;
   assign p1 = (sel == 1) ? pulse : 1'b0;
   assign p2 = (sel == 2) ? pulse : 1'b0;

   esticador_pulso #(.W(4), .GAP(0)) u0 (
      .clk(clk), .clr_n(clr_n), .pulse_in(p0), .len(len[3:0]), .ovr_clr(ovr_clr),
      .out(o0), .busy(b0), .overrun(v0));
   esticador_pulso #(.W(8), .GAP(1)) u1 (
      .clk(clk), .clr_n(clr_n), .pulse_in(p1), .len(len), .ovr_clr(ovr_clr),
      .out(o1), .busy(b1), .overrun(v1));
   esticador_pulso #(.W(8), .GAP(2)) u2 (
      .clk(clk), .clr_n(clr_n), .pulse_in(p2), .len(len), .ovr_clr(ovr_clr),
      .out(o2), .busy(b2), .overrun(v2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // drive inputs for the next edge, then queue the outputs expected after it
   task automatic cyc(input logic p, input logic [7:0] l, input logic oc,
                      input logic [2:0] exp, input string nm);
      entry_t e;
      pulse   = p;
      len     = l;
      ovr_clr = oc;
      @(posedge clk);
      #1;
      e.sel  = sel;
      e.exp  = exp;
      e.name = nm;
      q.push_back(e);
   endtask

   initial begin : monitor
      entry_t     e;
      logic [2:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
               0:       act = {o0, b0, v0};
               1:       act = {o1, b1, v1};
               default: act = {o2, b2, v2};
            endcase
            total++;
            if (act === e.exp)
               passed++;
            else
               $display("FAIL %s (dut%0d): out/busy/overrun got %b expected %b",
                        e.name, e.sel, act, e.exp);
         end
      end
   end

   initial begin : stim
      sel = 1; clr_n = 1'b0; pulse = 1'b0; len = 8'd0; ovr_clr = 1'b0;

      // reset dominates a live trigger
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'd5, 1'b0, 3'b000, "t1_reset");
      clr_n = 1'b1;
      cyc(1'b0, 8'd5, 1'b0, 3'b000, "t1_idle");

      // len=5, GAP=1
      cyc(1'b1, 8'd5, 1'b0, 3'b110, "t2_rise");
      for (int i = 0; i < 4; i++) cyc(1'b0, 8'd5, 1'b0, 3'b110, "t2_high");
      cyc(1'b0, 8'd5, 1'b0, 3'b010, "t2_guard");
      cyc(1'b0, 8'd5, 1'b0, 3'b000, "t2_idle");

      // len=0 ignored, len=1 single cycle
      cyc(1'b1, 8'd0, 1'b0, 3'b000, "t3_len0");
      cyc(1'b0, 8'd0, 1'b0, 3'b000, "t3_len0_after");
      cyc(1'b1, 8'd1, 1'b0, 3'b110, "t3_len1");
      cyc(1'b0, 8'd1, 1'b0, 3'b010, "t3_len1_guard");
      cyc(1'b0, 8'd1, 1'b0, 3'b000, "t3_len1_idle");

      // trigger during ACTIVE
      cyc(1'b1, 8'd4, 1'b0, 3'b110, "t4_rise");
      cyc(1'b0, 8'd4, 1'b0, 3'b110, "t4_high");
`ifdef RETRIGGER_EN
      cyc(1'b1, 8'd4, 1'b0, 3'b110, "t4_retrig");
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'd4, 1'b0, 3'b110, "t4_extended");
      cyc(1'b0, 8'd4, 1'b0, 3'b010, "t4_guard");
      cyc(1'b0, 8'd4, 1'b0, 3'b000, "t4_idle");
`else
      cyc(1'b1, 8'd4, 1'b0, 3'b111, "t4_drop");
      cyc(1'b0, 8'd4, 1'b0, 3'b111, "t4_high");
      cyc(1'b0, 8'd4, 1'b0, 3'b011, "t4_guard");
      cyc(1'b0, 8'd4, 1'b0, 3'b001, "t4_idle_sticky");
`endif
      cyc(1'b0, 8'd4, 1'b1, 3'b000, "t4_ovr_clr");

      // trigger exactly on the cnt==0 cycle
      cyc(1'b1, 8'd2, 1'b0, 3'b110, "t4b_rise");
      cyc(1'b0, 8'd2, 1'b0, 3'b110, "t4b_last");
`ifdef RETRIGGER_EN
      cyc(1'b1, 8'd2, 1'b0, 3'b110, "t4b_retrig_last");
      cyc(1'b0, 8'd2, 1'b0, 3'b110, "t4b_high");
      cyc(1'b0, 8'd2, 1'b0, 3'b010, "t4b_guard");
      cyc(1'b0, 8'd2, 1'b0, 3'b000, "t4b_idle");
`else
      cyc(1'b1, 8'd2, 1'b0, 3'b011, "t4b_drop_last");
      cyc(1'b0, 8'd2, 1'b0, 3'b001, "t4b_idle_sticky");
      cyc(1'b0, 8'd2, 1'b1, 3'b000, "t4b_ovr_clr");
`endif

      // GAP=2: drop in GUARD with ovr_clr -> set wins
      sel = 2;
      cyc(1'b1, 8'd3, 1'b0, 3'b110, "t5_rise");
      cyc(1'b0, 8'd3, 1'b0, 3'b110, "t5_high");
      cyc(1'b0, 8'd3, 1'b0, 3'b110, "t5_high");
      cyc(1'b0, 8'd3, 1'b0, 3'b010, "t5_guard1");
      cyc(1'b1, 8'd3, 1'b1, 3'b011, "t5_drop_set_wins");
      cyc(1'b0, 8'd3, 1'b1, 3'b000, "t5_clear");
      cyc(1'b1, 8'd3, 1'b0, 3'b110, "t5_restart");
      cyc(1'b0, 8'd3, 1'b0, 3'b110, "t5_high");
      cyc(1'b0, 8'd3, 1'b0, 3'b110, "t5_high");
      cyc(1'b0, 8'd3, 1'b0, 3'b010, "t5_guard1");
      cyc(1'b0, 8'd3, 1'b0, 3'b010, "t5_guard2");
      cyc(1'b0, 8'd3, 1'b0, 3'b000, "t5_idle");

      // reset mid-ACTIVE, then a full 200-cycle level
      sel = 1;
      cyc(1'b1, 8'd200, 1'b0, 3'b110, "t6_rise");
      for (int i = 0; i < 49; i++) cyc(1'b0, 8'd200, 1'b0, 3'b110, "t6_pre_reset");
      clr_n = 1'b0;
      cyc(1'b1, 8'd200, 1'b0, 3'b000, "t6_reset");
      clr_n = 1'b1;
      cyc(1'b1, 8'd200, 1'b0, 3'b110, "t6_rise2");
      for (int i = 0; i < 199; i++) cyc(1'b0, 8'd200, 1'b0, 3'b110, "t6_full");
      cyc(1'b0, 8'd200, 1'b0, 3'b010, "t6_guard");
      cyc(1'b0, 8'd200, 1'b0, 3'b000, "t6_idle");

      // GAP=0, W=4: max length, then one low cycle and an immediate restart
      sel = 0;
      cyc(1'b1, 8'd15, 1'b0, 3'b110, "t7_rise");
      for (int i = 0; i < 14; i++) cyc(1'b0, 8'd15, 1'b0, 3'b110, "t7_max");
      cyc(1'b0, 8'd15, 1'b0, 3'b000, "t7_no_guard");
      cyc(1'b1, 8'd1, 1'b0, 3'b110, "t7_restart");
      cyc(1'b0, 8'd1, 1'b0, 3'b000, "t7_idle");

      pulse = 1'b0;
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         total++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
